// File: rtl/imap_biu_if.sv
// Burst read channel between the imap bus interface unit and external memory.
// Address phase (AR) and data phase (R) each use a valid/ready handshake.
interface imap_biu_if;
  logic        mem_arvalid;
  logic        mem_arready;
  logic [31:0] mem_araddr;
  logic [7:0]  mem_arlen;
  logic        mem_rvalid;
  logic        mem_rready;
  logic [31:0] mem_rdata;
  logic        mem_rlast;

  // The unit issuing read bursts.
  modport master (
    output mem_arvalid,
    output mem_araddr,
    output mem_arlen,
    output mem_rready,
    input  mem_arready,
    input  mem_rvalid,
    input  mem_rdata,
    input  mem_rlast
  );

  // The memory answering read bursts.
  modport slave (
    input  mem_arvalid,
    input  mem_araddr,
    input  mem_arlen,
    input  mem_rready,
    output mem_arready,
    output mem_rvalid,
    output mem_rdata,
    output mem_rlast
  );
endinterface

// File: rtl/imap_biu.sv
// Input feature map bus interface unit.
// Fetches a contiguous block of 32-bit words from external memory in bursts
// of at most BURST_LEN beats, one burst outstanding at a time, and writes each
// returned word into the imap buffer exactly one cycle after it is accepted.
module imap_biu #(
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  imap_biu_if.master       mem,
  output logic [31:0]      imap_waddr,
  output logic [31:0]      imap_wdata,
  output logic             imap_wen
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  // Beats in the next burst: the full burst size, or whatever is left when
  // fewer than BURST_LEN words remain.
  function automatic logic [8:0] burst_beats(input logic [LEN_W-1:0] rem);
    logic [31:0] rem_ext;
    rem_ext = 32'(rem);
    if (rem_ext < BURST_LEN) begin
      return 9'(rem_ext);
    end
    return 9'(BURST_LEN);
  endfunction

  state_t           state_q;
  state_t           state_d;

  // Transfer context, loaded on an accepted start.
  logic [31:0]      cur_src_q;
  logic [31:0]      cur_dst_q;
  logic [LEN_W-1:0] rem_q;
  logic [7:0]       beat_cnt_q;
  logic [7:0]       last_idx_q;
  logic             err_q;

  // Registered buffer write port, one cycle behind the accepted beat.
  logic             wen_p1;
  logic [31:0]      waddr_p1;
  logic [31:0]      wdata_p1;

  logic             start_acc;
  logic             ar_hs;
  logic             beat;
  logic             beat_is_last;
  logic             last_beat;
  logic [7:0]       ar_len_m1;

  assign start_acc    = (state_q == S_IDLE) && start;
  assign ar_hs        = (state_q == S_AR) && mem.mem_arready;
  assign beat         = (state_q == S_R) && mem.mem_rvalid;
  assign beat_is_last = (beat_cnt_q == last_idx_q);
  assign last_beat    = beat && beat_is_last;
  assign ar_len_m1    = 8'(burst_beats(rem_q) - 9'd1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: burst sequencing is driven by the beat counter, never by rlast.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (len == '0) ? S_FIN : S_AR;
        end
      end
      S_AR: begin
        if (ar_hs) begin
          state_d = S_R;
        end
      end
      S_R: begin
        if (last_beat) begin
          state_d = (rem_q == LEN_W'(1)) ? S_FIN : S_AR;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: bus controls follow the state; address/length only while requesting.
  always_comb begin
    busy            = (state_q != S_IDLE);
    done            = (state_q == S_FIN);
    mem.mem_arvalid = (state_q == S_AR);
    mem.mem_araddr  = '0;
    mem.mem_arlen   = '0;
    mem.mem_rready  = (state_q == S_R);
    if (state_q == S_AR) begin
      mem.mem_araddr = cur_src_q;
      mem.mem_arlen  = ar_len_m1;
    end
  end

  // Transfer context: latch on start, size each burst at its handshake, advance per beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_src_q  <= '0;
      cur_dst_q  <= '0;
      rem_q      <= '0;
      beat_cnt_q <= '0;
      last_idx_q <= '0;
    end else if (start_acc) begin
      cur_src_q  <= {src_addr[31:2], 2'b00};
      cur_dst_q  <= dst_addr;
      rem_q      <= len;
      beat_cnt_q <= '0;
    end else if (ar_hs) begin
      last_idx_q <= ar_len_m1;
      beat_cnt_q <= '0;
    end else if (beat) begin
      cur_src_q  <= cur_src_q + 32'd4;
      cur_dst_q  <= cur_dst_q + 32'd1;
      rem_q      <= (rem_q != '0) ? rem_q - LEN_W'(1) : rem_q;
      beat_cnt_q <= beat_is_last ? 8'd0 : beat_cnt_q + 8'd1;
    end
  end

  // Sticky framing error: rlast must mark exactly the counted last beat of a burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (start_acc) begin
      err_q <= 1'b0;
    end else if (beat && (mem.mem_rlast != beat_is_last)) begin
      err_q <= 1'b1;
    end
  end

  // ---- stage p1: buffer write of the beat accepted in the previous cycle ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else begin
      wen_p1 <= beat;
      if (beat) begin
        waddr_p1 <= cur_dst_q;
        wdata_p1 <= mem.mem_rdata;
      end
    end
  end

  assign err        = err_q;
  assign imap_wen   = wen_p1;
  assign imap_waddr = waddr_p1;
  assign imap_wdata = wdata_p1;

endmodule

// File: tb/tb_imap_biu.sv
// Self-checking bench for imap_biu: a behavioural memory slave plus a
// reference model that derives expected bursts and buffer writes directly
// from the transfer parameters.
module tb_imap_biu;
  localparam int BL = 16;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   src_addr = '0;
  logic [31:0]   dst_addr = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, err, imap_wen;
  logic [31:0]   imap_waddr, imap_wdata;

  imap_biu_if bus();

  imap_biu #(.BURST_LEN(BL), .LEN_W(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem       (bus),
    .imap_waddr(imap_waddr),
    .imap_wdata(imap_wdata),
    .imap_wen  (imap_wen)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] waddr; logic [31:0] wdata; } wr_t;
  typedef struct { logic [31:0] addr;  logic [7:0]  alen;  } ar_t;

  int  checks = 0;
  int  fails  = 0;
  wr_t exp_w[$];
  ar_t exp_ar[$];
  int  wr_cnt, done_cnt, ar_cnt, arv_cycles, exp_len;
  logic [31:0] exp_last_waddr;
  bit  rnd_mode = 1'b0;
  int  inject_idx = -1;

  // memory slave state
  bit          s_active;
  logic [31:0] s_addr;
  int          s_beats, s_idx, s_wait;
  bit          beat_pend;
  bit          prev_arv_wait;
  logic [31:0] prev_araddr;
  logic [7:0]  prev_arlen;
  bit          ar_hs;
  wr_t         e_w;
  ar_t         e_ar;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Memory slave and write-port monitor, both evaluated away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.mem_arready = 1'b0;
      bus.mem_rvalid  = 1'b0;
      bus.mem_rdata   = '0;
      bus.mem_rlast   = 1'b0;
      s_active = 1'b0;
      s_idx = 0;
      beat_pend = 1'b0;
      prev_arv_wait = 1'b0;
    end else begin
      if (imap_wen || beat_pend)
        chk("wr_latency", {31'd0, imap_wen}, {31'd0, beat_pend});
      if (imap_wen) begin
        wr_cnt++;
        if (exp_w.size() == 0) begin
          chk("wr_unexpected", 32'd1, 32'd0);
        end else begin
          e_w = exp_w.pop_front();
          chk("waddr", imap_waddr, e_w.waddr);
          chk("wdata", imap_wdata, e_w.wdata);
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_busy", {31'd0, busy}, 32'd1);
        if (exp_len > 0) begin
          chk("done_wen", {31'd0, imap_wen}, 32'd1);
          chk("done_waddr", imap_waddr, exp_last_waddr);
        end else begin
          chk("done_nowen", {31'd0, imap_wen}, 32'd0);
        end
      end
      if (bus.mem_arvalid) begin
        arv_cycles++;
        if (prev_arv_wait) begin
          chk("araddr_hold", bus.mem_araddr, prev_araddr);
          chk("arlen_hold", {24'd0, bus.mem_arlen}, {24'd0, prev_arlen});
        end
      end
      // data channel
      if (s_active) begin
        bus.mem_rvalid = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.mem_rdata  = memf(s_addr + 32'(4 * s_idx));
        bus.mem_rlast  = (s_idx == s_beats - 1) || (s_idx == inject_idx);
        if (bus.mem_rvalid && bus.mem_rready) begin
          s_idx++;
          if (s_idx == s_beats) s_active = 1'b0;
        end
      end else begin
        bus.mem_rvalid = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.mem_rdata  = $urandom;
        bus.mem_rlast  = 1'($urandom_range(0, 1));
      end
      beat_pend = bus.mem_rvalid && bus.mem_rready;
      // address channel
      bus.mem_arready = 1'b0;
      if (bus.mem_arvalid && !s_active) begin
        if (s_wait > 0) s_wait--;
        else bus.mem_arready = 1'b1;
      end
      ar_hs = bus.mem_arvalid && bus.mem_arready;
      prev_arv_wait = bus.mem_arvalid && !bus.mem_arready;
      prev_araddr = bus.mem_araddr;
      prev_arlen  = bus.mem_arlen;
      if (ar_hs) begin
        ar_cnt++;
        if (exp_ar.size() == 0) begin
          chk("ar_unexpected", 32'd1, 32'd0);
        end else begin
          e_ar = exp_ar.pop_front();
          chk("ar_addr", bus.mem_araddr, e_ar.addr);
          chk("ar_len", {24'd0, bus.mem_arlen}, {24'd0, e_ar.alen});
        end
        s_active = 1'b1;
        s_addr   = bus.mem_araddr;
        s_beats  = int'(bus.mem_arlen) + 1;
        s_idx    = 0;
        s_wait   = rnd_mode ? int'($urandom_range(0, 5)) : 0;
      end
    end
  end

  // Reference model: split the block into bursts and list every buffer write.
  task automatic build_exp(input logic [31:0] s, input logic [31:0] d, input int n);
    logic [31:0] a;
    logic [31:0] ba;
    int rem, k;
    exp_w.delete();
    exp_ar.delete();
    a = s & ~32'h3;
    for (int i = 0; i < n; i++)
      exp_w.push_back('{waddr: d + 32'(i), wdata: memf(a + 32'(4 * i))});
    ba = a;
    rem = n;
    while (rem > 0) begin
      k = (rem < BL) ? rem : BL;
      exp_ar.push_back('{addr: ba, alen: 8'(k - 1)});
      ba += 32'(4 * k);
      rem -= k;
    end
    exp_len = n;
    exp_last_waddr = d + 32'(n - 1);
    wr_cnt = 0;
    done_cnt = 0;
    ar_cnt = 0;
    arv_cycles = 0;
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input int n);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    len = 16'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    src_addr = $urandom;
    dst_addr = $urandom;
    len = 16'($urandom);
  endtask

  task automatic wait_done(input int lim);
    int t;
    t = 0;
    while (done_cnt == 0 && t < lim) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int n,
                          input bit rnd, input bit exp_err, input bit dbl);
    rnd_mode = rnd;
    s_wait = rnd ? int'($urandom_range(0, 5)) : 0;
    build_exp(s, d, n);
    pulse_start(s, d, n);
    chk("err_clear_on_start", {31'd0, err}, 32'd0);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    if (n == 0) chk("zero_done_next", {31'd0, done}, 32'd1);
    if (dbl) begin
      repeat (3) @(negedge clk);
      src_addr = 32'h0009_0000;
      dst_addr = 32'h0000_0700;
      len = 16'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(4000);
    if (dbl) repeat (20) @(negedge clk);
    chk("wr_count", 32'(wr_cnt), 32'(n));
    chk("ar_left", 32'(exp_ar.size()), 32'd0);
    chk("err_final", {31'd0, err}, {31'd0, exp_err});
    @(negedge clk);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("done_once", 32'(done_cnt), 32'd1);
    if (n == 0) begin
      chk("zero_no_arvalid", 32'(arv_cycles), 32'd0);
      chk("zero_no_wen", 32'(wr_cnt), 32'd0);
    end
  endtask

  task automatic check_zero(input string p);
    chk({p, "_busy"},   {31'd0, busy}, 32'd0);
    chk({p, "_done"},   {31'd0, done}, 32'd0);
    chk({p, "_err"},    {31'd0, err}, 32'd0);
    chk({p, "_arv"},    {31'd0, bus.mem_arvalid}, 32'd0);
    chk({p, "_araddr"}, bus.mem_araddr, 32'd0);
    chk({p, "_arlen"},  {24'd0, bus.mem_arlen}, 32'd0);
    chk({p, "_rready"}, {31'd0, bus.mem_rready}, 32'd0);
    chk({p, "_wen"},    {31'd0, imap_wen}, 32'd0);
    chk({p, "_waddr"},  imap_waddr, 32'd0);
    chk({p, "_wdata"},  imap_wdata, 32'd0);
  endtask

  initial begin
    int d0, t, n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // three bursts, last one partial
    run_xfer(32'h0000_1000, 32'h0000_0000, 40, 1'b0, 1'b0, 1'b0);
    // random rvalid gaps and slow arready
    run_xfer(32'h0000_2004, 32'h0000_0100, 17, 1'b1, 1'b0, 1'b0);
    // zero length
    run_xfer(32'h0000_3000, 32'h0000_0200, 0, 1'b0, 1'b0, 1'b0);
    // second start while busy is ignored
    run_xfer(32'h0000_4000, 32'h0000_0300, 8, 1'b0, 1'b0, 1'b1);
    // early rlast on beat 10 of 16
    inject_idx = 9;
    run_xfer(32'h0000_5000, 32'h0000_0400, 16, 1'b0, 1'b1, 1'b0);
    inject_idx = -1;
    repeat (4) @(negedge clk);
    chk("err_sticky", {31'd0, err}, 32'd1);
    run_xfer(32'h0000_6000, 32'h0000_0500, 3, 1'b0, 1'b0, 1'b0);
    // address wrap and unaligned source
    run_xfer(32'hFFFF_FFE3, 32'hFFFF_FFFE, 20, 1'b1, 1'b0, 1'b0);
    // random transfers
    for (int i = 0; i < 6; i++) begin
      n = int'($urandom_range(1, 45));
      run_xfer($urandom, $urandom, n, 1'b1, 1'b0, 1'b0);
    end

    // reset in the middle of a burst
    rnd_mode = 1'b0;
    s_wait = 0;
    build_exp(32'h0000_7000, 32'h0000_0040, 32);
    pulse_start(32'h0000_7000, 32'h0000_0040, 32);
    t = 0;
    while (wr_cnt < 5 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("rst_reach_beat5", {31'd0, wr_cnt >= 5}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    exp_w.delete();
    exp_ar.delete();
    d0 = done_cnt;
    repeat (5) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt), 32'(d0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", {31'd0, busy}, 32'd0);
    run_xfer(32'h0000_8000, 32'h0000_0080, 4, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
